shift_arbiter64: RTL

SHIFT_ARBITER64 -- requirements
Module: shift_arbiter64

---
 rtl/shift_arbiter64.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/shift_arbiter64.sv
// shift_arbiter64
//   Four-requester round-robin front end for one shared 64-bit barrel shifter.
//   Each cycle one valid requester is picked by round-robin search starting at
//   rr_ptr. Its operand, amount and type go to the shifter combinationally. The
//   shifter result is captured in a 1-entry response register. That register
//   can be replaced in the same cycle it drains, so the block sustains one
//   operation per cycle.
//
// Configuration macro: SHIFT_ARB_HIPRI_EN
//   When defined, requester 0 has absolute priority and round-robin applies
//   only among requesters 1-3. A requester-0 grant leaves rr_ptr untouched.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid[3:0]    per-requester request valid
//   req_ready[3:0]    per-requester accept strobe (one-hot or zero)
//   req_in[255:0]     four 64-bit operands, requester i at [64i+63:64i]
//   req_shift_amount  four 6-bit amounts, requester i at [6i+5:6i]
//   req_shift_type    four 2-bit types (00 LSL, 01 LSR, 10 ASL, 11 ASR)
//   sh_in/sh_shift_amount/sh_shift_type  drive to the shared shifter
//   sh_result         combinational result from the shared shifter
//   rsp_valid/rsp_ready/rsp_id/rsp_result  registered response handshake
module shift_arbiter64 (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [255:0] req_in,
  input  logic [23:0]  req_shift_amount,
  input  logic [7:0]   req_shift_type,
  output logic [63:0]  sh_in,
  output logic [5:0]   sh_shift_amount,
  output logic [1:0]   sh_shift_type,
  input  logic [63:0]  sh_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [1:0]   rsp_id,
  output logic [63:0]  rsp_result
);

  logic [1:0] rr_ptr;
  logic [1:0] winner;
  logic       any_valid;
  logic       can_accept;
  logic       handshake;
  logic [3:0] rr_mask;

  // Round-robin winner search starting at rr_ptr, wrapping modulo 4.
  always_comb begin
    winner    = 2'd0;
    any_valid = 1'b0;
`ifdef SHIFT_ARB_HIPRI_EN
    // Requester 0 is handled by the priority override below.
    rr_mask   = req_valid & 4'b1110;
`else
    rr_mask   = req_valid;
`endif
    for (int k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = rr_ptr + 2'(k);
      if (!any_valid && rr_mask[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end else begin
        any_valid = any_valid;
      end
    end
`ifdef SHIFT_ARB_HIPRI_EN
    if (req_valid[0]) begin
      any_valid = 1'b1;
      winner    = 2'd0;
    end else begin
      any_valid = any_valid;
    end
`endif
  end

  // The response slot is free when empty or draining this cycle; nothing is
  // granted while reset is held.
  assign can_accept = !rsp_valid || rsp_ready;
  assign handshake  = any_valid && can_accept && !rst;

  // Grant strobe and shifter operand steering; all zero when no handshake.
  always_comb begin
    req_ready       = 4'b0000;
    sh_in           = 64'd0;
    sh_shift_amount = 6'd0;
    sh_shift_type   = 2'b00;
    if (handshake) begin
      req_ready = 4'b0001 << winner;
      case (winner)
        2'd0: begin
          sh_in           = req_in[63:0];
          sh_shift_amount = req_shift_amount[5:0];
          sh_shift_type   = req_shift_type[1:0];
        end
        2'd1: begin
          sh_in           = req_in[127:64];
          sh_shift_amount = req_shift_amount[11:6];
          sh_shift_type   = req_shift_type[3:2];
        end
        2'd2: begin
          sh_in           = req_in[191:128];
          sh_shift_amount = req_shift_amount[17:12];
          sh_shift_type   = req_shift_type[5:4];
        end
        2'd3: begin
          sh_in           = req_in[255:192];
          sh_shift_amount = req_shift_amount[23:18];
          sh_shift_type   = req_shift_type[7:6];
        end
        default: begin
          sh_in           = 64'd0;
          sh_shift_amount = 6'd0;
          sh_shift_type   = 2'b00;
        end
      endcase
    end else begin
      req_ready = 4'b0000;
    end
  end

  // Response register and round-robin pointer update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 2'd0;
      rsp_result <= 64'd0;
      rr_ptr     <= 2'd0;
    end else if (handshake) begin
      // A new result replaces a draining one with no bubble.
      rsp_valid  <= 1'b1;
      rsp_id     <= winner;
      rsp_result <= sh_result;
`ifdef SHIFT_ARB_HIPRI_EN
      if (winner != 2'd0) begin
        rr_ptr <= winner + 2'd1;
      end else begin
        rr_ptr <= rr_ptr;
      end
`else
      rr_ptr     <= winner + 2'd1;
`endif
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end else begin
      rsp_valid  <= rsp_valid;
    end
  end

endmodule
